// File: rtl/io_event_pkg.sv
// Shared helpers for the io event capture block (FIFO addressing).
package io_event_pkg;

    // Address bits needed to index a FIFO of the given (power-of-two) depth.
    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/io_event_fifo.sv
// Show-ahead event FIFO: head entry is visible whenever not empty.
// Wrap-bit pointers separate full from empty; a push into a full FIFO succeeds only alongside a pop.
module io_event_fifo
    import io_event_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_io,
    input  logic [TS_WIDTH-1:0] push_ts,
    input  logic                pop,
    output logic [WIDTH-1:0]    head_io,
    output logic [TS_WIDTH-1:0] head_ts,
    output logic                empty,
    output logic                full,
    output logic                dropped
);
    localparam int AW = fifo_addr_w(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0]    io;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && full && !do_pop;
    assign wr_entry = '{io: push_io, ts: push_ts};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // When full, the write slot equals the head slot being popped this cycle.
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_entry;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign head_io = empty ? '0 : mem[rd_ptr[AW-1:0]].io;
    assign head_ts = empty ? '0 : mem[rd_ptr[AW-1:0]].ts;

endmodule

// File: rtl/io_event_capture.sv
// Synchronises an async io bus, detects masked edges and logs timestamped events into a FIFO.
// Optional per-bit debounce filter is compiled in with IO_EVENT_CAPTURE_DEBOUNCE_EN.
module io_event_capture
    import io_event_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int TS_WIDTH        = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    io_in,
    input  logic                enable,
    input  logic [WIDTH-1:0]    rise_mask,
    input  logic [WIDTH-1:0]    fall_mask,
    output logic [WIDTH-1:0]    level_out,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [WIDTH-1:0]    ev_io,
    output logic [TS_WIDTH-1:0] ev_ts,
    output logic                ev_overflow,
    input  logic                clr_overflow
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  filt;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  evt;
    logic [TS_WIDTH-1:0]               ts_q;
    logic                              push;
    logic                              fifo_empty;
    logic                              fifo_full;
    logic                              dropped;

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IO_EVENT_CAPTURE_DEBOUNCE_EN
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar b = 0; b < WIDTH; b++) begin : g_deb
        logic [CW-1:0] cnt_q;
        logic          lvl_q;

        // Level only follows the input after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync_out[b] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                lvl_q <= sync_out[b];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign filt[b] = lvl_q;
    end
`else
    assign filt = sync_out;
`endif

    assign evt  = (filt & ~prev_q & rise_mask) | (~filt & prev_q & fall_mask);
    assign push = (|evt) && enable;

    // prev tracks the level even while disabled, so re-enabling never replays an old change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            prev_q      <= '0;
            ts_q        <= '0;
            ev_overflow <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
            prev_q <= filt;
            ts_q   <= ts_q + TS_WIDTH'(1);
            if (dropped)           ev_overflow <= 1'b1;
            else if (clr_overflow) ev_overflow <= 1'b0;
        end
    end

    assign level_out = filt;
    assign ev_valid  = !fifo_empty;

    io_event_fifo #(
        .WIDTH    (WIDTH),
        .TS_WIDTH (TS_WIDTH),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_io (filt),
        .push_ts (ts_q),
        .pop     (ev_ready),
        .head_io (ev_io),
        .head_ts (ev_ts),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .dropped (dropped)
    );

endmodule

// File: tb/tb_io_event_capture.sv
// Directed bench for io_event_capture: queue-based event model checked every cycle, plus literal checks.
module tb_io_event_capture;
    localparam int W = 4, TSW = 16, DEPTH = 8, SYNC = 2, DEB = 4;
`ifdef IO_EVENT_CAPTURE_DEBOUNCE_EN
    localparam int X = DEB;
`else
    localparam int X = 0;
`endif
    localparam int GAP = (X > 0) ? DEB + 2 : 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   io_in = '0, rise_mask = 4'b0001, fall_mask = '0;
    logic           enable = 1'b1, ev_ready = 1'b1, clr_overflow = 1'b0;
    logic [W-1:0]   level_out, ev_io;
    logic [TSW-1:0] ev_ts;
    logic           ev_valid, ev_overflow;

    logic           io2 = 1'b0, ready2 = 1'b0;
    logic [0:0]     lvl2, evio2;
    logic [3:0]     ts2;
    logic           valid2, ov2;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [TSW-1:0] popped[$];

    always #5 clk = ~clk;

    io_event_capture #(.WIDTH(W), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC),
                       .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .io_in(io_in), .enable(enable), .rise_mask(rise_mask),
        .fall_mask(fall_mask), .level_out(level_out), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_io(ev_io), .ev_ts(ev_ts), .ev_overflow(ev_overflow), .clr_overflow(clr_overflow));

    io_event_capture #(.WIDTH(1), .TS_WIDTH(4), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC),
                       .DEBOUNCE_CYCLES(DEB)) dut2 (
        .clk(clk), .rst(rst), .io_in(io2), .enable(1'b1), .rise_mask(1'b1),
        .fall_mask(1'b1), .level_out(lvl2), .ev_valid(valid2), .ev_ready(ready2),
        .ev_io(evio2), .ev_ts(ts2), .ev_overflow(ov2), .clr_overflow(1'b0));

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [W-1:0] io; logic [TSW-1:0] ts; } mev_t;
    mev_t           m_q[$];
    logic [W-1:0]   hist[$];
    logic [W-1:0]   m_f, m_prev;
    logic [TSW-1:0] m_ts;
    bit             m_ov;
    int             m_run[W];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete(); hist.delete();
                m_f = '0; m_prev = '0; m_ts = '0; m_ov = 0;
                for (int b = 0; b < W; b++) m_run[b] = 0;
            end else begin
                logic [W-1:0] evt, s_cur;
                bit pop;
                int sz;
                evt   = (m_f & ~m_prev & rise_mask) | (~m_f & m_prev & fall_mask);
                sz    = m_q.size();
                pop   = (sz > 0) && ev_ready;
                if (pop) void'(m_q.pop_front());
                if ((|evt) && enable && (sz < DEPTH || pop)) m_q.push_back('{m_f, m_ts});
                if ((|evt) && enable && sz == DEPTH && !pop) m_ov = 1;
                else if (clr_overflow)                        m_ov = 0;
                m_prev = m_f;
                m_ts   = m_ts + 1'b1;
                // synchroniser output = io sample taken SYNC-1 edges before the latest
                s_cur  = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : '0;
                hist.push_back(io_in);
                if (hist.size() > 8) void'(hist.pop_front());
`ifdef IO_EVENT_CAPTURE_DEBOUNCE_EN
                for (int b = 0; b < W; b++) begin
                    if (s_cur[b] != m_f[b]) begin
                        m_run[b]++;
                        if (m_run[b] == DEB) begin m_f[b] = s_cur[b]; m_run[b] = 0; end
                    end else m_run[b] = 0;
                end
`else
                m_f = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : '0;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", ev_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("ev_io", ev_io, m_q[0].io);
                chk("ev_ts", ev_ts, m_q[0].ts);
            end
            chk("overflow", ev_overflow, m_ov);
            chk("level", level_out, m_f);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic at(input int c);
        while (cyc < c) begin @(posedge clk); #2; end
    endtask

    task automatic toggle0();
        io_in[0] = ~io_in[0];
    endtask

    task automatic drain();
        popped.delete();
        ev_ready = 1'b1;
        repeat (20) begin
            if (ev_valid) popped.push_back(ev_ts);
            @(posedge clk); #2;
        end
        ev_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_ts", ev_ts, 0);
        chk("rst_ovf", ev_overflow, 0);
        chk("rst_level", level_out, 0);
        chk("rst_valid2", valid2, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // single rising event
        at(10); io_in = 4'b0001;
        at(12); #4 chk("t1_idle", ev_valid, 0);
        at(13 + X); #4;
        chk("t1_valid", ev_valid, 1);
        chk("t1_io", ev_io, 4'b0001);
        chk("t1_ts", ev_ts, 12 + X);
        at(14 + X); #4 chk("t1_pulse", ev_valid, 0);
        at(20); io_in = 4'b0000;

        // fill past capacity, then drain in order
        at(30); ev_ready = 1'b0; rise_mask = 4'b0001; fall_mask = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            at(30 + 6*i);
            if (i == 8) begin #4 chk("t2_ovf_before", ev_overflow, 0); end
            toggle0();
        end
        at(95); #4;
        chk("t2_ovf_set", ev_overflow, 1);
        chk("t2_head_ts", ev_ts, 32 + X);
        at(100); drain();
        chk("t2_count", popped.size(), 8);
        if (popped.size() == 8)
            for (int i = 0; i < 8; i++) chk("t2_order", popped[i], 32 + X + 6*i);

        // full FIFO with simultaneous push and pop
        at(130); clr_overflow = 1'b1;
        at(131); clr_overflow = 1'b0;
        for (int i = 0; i < 8; i++) begin at(140 + 6*i); toggle0(); end
        at(200); toggle0();
        at(202 + X); ev_ready = 1'b1;
        at(203 + X); ev_ready = 1'b0;
        at(206 + X); #4 chk("t3_ovf_clear", ev_overflow, 0);
        at(210); drain();
        chk("t3_count", popped.size(), 8);
        if (popped.size() == 8) begin
            chk("t3_first", popped[0], 148 + X);
            chk("t3_last", popped[7], 202 + X);
        end

        // clear request coinciding with a drop: set wins
        for (int i = 0; i < 9; i++) begin
            at(240 + 6*i);
            if (i == 8) begin #4 chk("t3b_ovf_before", ev_overflow, 0); end
            toggle0();
        end
        at(290 + X); clr_overflow = 1'b1;
        at(291 + X); clr_overflow = 1'b0;
        at(293 + X); #4 chk("t3b_ovf_kept", ev_overflow, 1);
        at(300); drain();
        clr_overflow = 1'b1;
        at(cyc + 1); clr_overflow = 1'b0;

        // change while disabled never turns into an event
        at(330); enable = 1'b0; toggle0();
        at(345); enable = 1'b1;
        at(360); #4 chk("t4_no_event", ev_valid, 0);

        // several bits in one cycle -> one event, unmasked bits ignored
        at(370); rise_mask = '0; fall_mask = '0; io_in = 4'b0000; ev_ready = 1'b1;
        at(380); rise_mask = 4'b1010; io_in = 4'b1111;
        at(383 + X); #4;
        chk("t5_valid", ev_valid, 1);
        chk("t5_io", ev_io, 4'hF);
        chk("t5_ts", ev_ts, 382 + X);
        at(390); io_in = 4'b0101;
        at(400); #4;
        chk("t5_single", ev_valid, 0);
        chk("t5_level", level_out, 4'b0101);

        // reset mid-operation, then first post-reset sample against prev=0
        at(410); ev_ready = 1'b0; rise_mask = 4'b0001; io_in = 4'b0100;
        at(420); io_in = 4'b0101;
        at(430); #4 chk("t6_pending", ev_valid, 1);
        rst = 1'b1;
        #2;
        chk("t6_rst_valid", ev_valid, 0);
        chk("t6_rst_ovf", ev_overflow, 0);
        chk("t6_rst_level", level_out, 0);
        @(posedge clk); #2 rst = 1'b0;
        at(3 + X); #4;
        chk("t6_post_valid", ev_valid, 1);
        chk("t6_post_ts", ev_ts, 2 + X);
        chk("t6_post_io", ev_io, 4'b0101);

        // timestamp wrap on the 4-bit instance
        at(32 + ((13 - X) & 15)); io2 = 1'b1;
        at(32 + ((13 - X) & 15) + GAP); io2 = 1'b0;
        at(32 + ((13 - X) & 15) + GAP + 10); #4;
        chk("t7_valid", valid2, 1);
        chk("t7_ts_first", ts2, 15);
        chk("t7_io_first", evio2, 1);
        chk("t7_ovf", ov2, 0);
        ready2 = 1'b1;
        @(posedge clk); #2 ready2 = 1'b0;
        #4;
        chk("t7_ts_second", ts2, (15 + GAP) % 16);
        chk("t7_io_second", evio2, 0);

`ifdef IO_EVENT_CAPTURE_DEBOUNCE_EN
        // glitch shorter than the debounce window is filtered out
        ev_ready = 1'b1; rise_mask = 4'b0010; fall_mask = '0;
        at(100); io_in[1] = 1'b1;
        at(103); io_in[1] = 1'b0;
        at(120); #4 chk("t8_glitch", ev_valid, 0);
        ev_ready = 1'b0;
        at(130); io_in[1] = 1'b1;
        at(136); io_in[1] = 1'b0;
        at(130 + SYNC + DEB); #4 chk("t8_early", ev_valid, 0);
        at(131 + SYNC + DEB); #4;
        chk("t8_valid", ev_valid, 1);
        chk("t8_ts", ev_ts, 130 + SYNC + DEB);
`endif

        at(cyc + 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
